bist_addr_gen: RTL and testbench
================================

# bist_addr_gen

Parametrised MBIST address generator, successor to the single-field bist counter. Sweeps a programmable rectangular address window {row, col} up or down, with either the column or the row as the fast axis. Provides a terminal-count pulse, a sticky sweep-done flag and a configuration-error flag. It sits between the March-element sequencer (which issues `ld`/`cen`) and the memory address port.

## Interface
- `ADDR_W`, 12, total address width; address = {row, col}.
- `ROW_W`, 6, row field width; `COL_W = ADDR_W-ROW_W`; `1 <= ROW_W < ADDR_W`.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `ld` in 1: load window, direction and mode; position q at the start address.
- `cen` in 1: count enable; one step per cycle.
- `dir` in 1: 0 = up, 1 = down; sampled only on `ld`.
- `mode` in 1: 0 = column-fast, 1 = row-fast; sampled only on `ld`.
- `lo_in` in ADDR_W: window low corner {row_lo, col_lo}.
- `hi_in` in ADDR_W: window high corner {row_hi, col_hi}.
- `q` out ADDR_W: current address (registered).
- `last` out 1: combinational; q equals the terminal address and `cfg_err` = 0.
- `cout` out 1: registered one-cycle pulse, high in the cycle after the wrap step.
- `done` out 1: sticky; set on the first wrap, cleared by `ld` or `reset`.
- `cfg_err` out 1: registered; set by an `ld` whose row_lo > row_hi or col_lo > col_hi.

## Operation
- Window is the rectangle row ∈ [row_lo, row_hi], col ∈ [col_lo, col_hi], with bounds compared per field.
- Start address: up → {row_lo, col_lo}; down → {row_hi, col_hi}.
- Terminal address: up → {row_hi, col_hi}; down → {row_lo, col_lo}.
- Step:
  - The fast axis moves ±1.
  - When the fast axis is at its terminal bound, it reloads its start bound and the slow axis moves ±1.
  - When both fields are at terminal, both reload start; this is the wrap.
- Wrap effects:
  - q returns to the start address.
  - `cout` = 1 for exactly the next cycle.
  - `done` is set.
  - Counting continues; there is no auto-stop.
- Priority: `reset` > `ld` > `cen`.
  - `ld` with `cen` = 1 in the same cycle: the load wins and no step occurs.
- Valid `ld`:
  - Latches lo, hi, dir and mode.
  - Sets q to start.
  - Clears `done`, `cout` and `cfg_err`.
- Invalid `ld` (either field lo > hi):
  - Latches nothing and leaves q unchanged.
  - Sets `cfg_err` = 1.
  - `cen` is ignored, `last` = 0 and `cout` = 0 until the next valid `ld`.
- `cen` = 0: q, `done` and `cfg_err` hold; `cout` = 0.
- `dir`/`mode` changes without `ld` have no effect mid-sweep.
- No arithmetic overflow is possible: each field stays within [lo, hi] ⊆ [0, 2^width − 1].

## Timing
- Reset values (cycle after `reset` is sampled high):
  - q = 0, `cout` = 0, `done` = 0, `cfg_err` = 0.
  - Window = full range (lo = 0, hi = all ones), dir = up, mode = column-fast.
  - Hence `last` = 0.
- Reset mid-sweep: the same values apply on the next edge, and any pending `cout` is suppressed.
- `ld` → q = start on the next edge (latency 1).
- `cen` → q updates on the same edge (latency 1); one step per enabled cycle.
- `cout` is asserted in the cycle where q first shows the start address after the wrap, and is deasserted the following cycle unless another wrap occurs.
- Degenerate window (lo = hi): every enabled cycle is a wrap, so `last` stays 1 and `cout` stays 1 while `cen` = 1.
- One-field-wide window (e.g. row_lo = row_hi): the slow/fast carry still applies and the sweep length is the product of the field spans.

## Structure
- Shared package `bist_pkg`:
  - `dir_e` (`DIR_UP`, `DIR_DOWN`).
  - `axis_mode_e` (`COL_FAST`, `ROW_FAST`).
  - Shared with the March sequencer.
- Sub-module `bist_axis_counter #(W)`, instantiated twice (row, col):
  - Inputs: `clk`, `reset`, `ld`, `lo`, `hi`, `dir`, `step`.
  - Outputs: `val`, `at_term`.
  - Wraps to its start bound on a step taken while `at_term` = 1.
- Top level: mode muxing of the step/carry chain between the two axes, config validation, `cout`/`done`/`cfg_err` registers, `last` decode.

## Test plan
- Full sweep, column-fast up (ADDR_W = 12, ROW_W = 6):
  - Stimulus: `reset`; `ld` lo = 0x000, hi = 0xFFF, dir = 0, mode = 0; `cen` = 1.
  - Required: q = 0x000, 0x001, …, 0xFFF, then 0x000 after 4096 steps; `cout` high exactly one cycle at that point; `done` = 1 thereafter.
- Row-fast down, window rows 2–3, cols 5–6:
  - Stimulus: lo = 0x085, hi = 0x0C6, dir = 1, mode = 1.
  - Required: q = 0x0C6 → 0x086 → 0x0C5 → 0x085 → 0x0C6 with `cout` = 1; `last` = 1 only while q = 0x085.
- Single address:
  - Stimulus: lo = hi = 0x123, `cen` = 1 for 5 cycles.
  - Required: q stays 0x123; `last` = 1 throughout; `cout` = 1 for 5 consecutive cycles; `done` = 1.
- Bad config:
  - Stimulus: `ld` lo = 0x0C0, hi = 0x085 (row_lo = 3 > row_hi = 2).
  - Required: `cfg_err` = 1; q held; `cen` ignored. A following valid `ld` clears `cfg_err` and q = start.
- Priority and reset:
  - `ld` and `cen` high together → q = start with no step.
  - `cen` low for 3 cycles → q held.
  - `dir`/`mode` toggled mid-sweep → sweep order unchanged.
  - `reset` asserted at q = 0x7FF → q = 0 and `cout` = `done` = 0 on the next edge.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared MBIST types: sweep direction and fast-axis selection.
package bist_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        COL_FAST = 1'b0,
        ROW_FAST = 1'b1
    } axis_mode_e;

    localparam int unsigned BIST_ADDR_W_DEFAULT = 12;
    localparam int unsigned BIST_ROW_W_DEFAULT  = 6;

endpackage : bist_pkg

// File: rtl/bist_axis_counter.sv
// One address field counter: bounded up/down count that wraps to its start bound.
module bist_axis_counter
    import bist_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  dir_e         dir,
    input  logic         step,
    output logic [W-1:0] val,
    output logic         at_term
);

    logic [W-1:0] r_lo;
    logic [W-1:0] r_hi;
    dir_e         r_dir;
    logic [W-1:0] r_val;

    logic [W-1:0] w_start;
    logic [W-1:0] w_term;
    logic [W-1:0] w_ld_start;

    // Start/terminal bounds follow the latched direction.
    always_comb begin
        w_start    = (r_dir == DIR_UP) ? r_lo : r_hi;
        w_term     = (r_dir == DIR_UP) ? r_hi : r_lo;
        w_ld_start = (dir == DIR_UP) ? lo : hi;
    end

    // Window/direction latch and position register; load beats step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo  <= '0;
            r_hi  <= '1;
            r_dir <= DIR_UP;
            r_val <= '0;
        end else if (ld) begin
            r_lo  <= lo;
            r_hi  <= hi;
            r_dir <= dir;
            r_val <= w_ld_start;
        end else if (step) begin
            if (at_term) begin
                r_val <= w_start;
            end else if (r_dir == DIR_UP) begin
                r_val <= r_val + W'(1);
            end else begin
                r_val <= r_val - W'(1);
            end
        end
    end

    assign val     = r_val;
    assign at_term = (r_val == w_term);

endmodule : bist_axis_counter

// File: rtl/bist_addr_gen.sv
// MBIST rectangular-window address generator with selectable fast axis.
module bist_addr_gen
    import bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned ROW_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld,
    input  logic              cen,
    input  logic              dir,
    input  logic              mode,
    input  logic [ADDR_W-1:0] lo_in,
    input  logic [ADDR_W-1:0] hi_in,
    output logic [ADDR_W-1:0] q,
    output logic              last,
    output logic              cout,
    output logic              done,
    output logic              cfg_err
);

    localparam int unsigned COL_W = ADDR_W - ROW_W;

    logic [ROW_W-1:0] w_lo_row;
    logic [ROW_W-1:0] w_hi_row;
    logic [COL_W-1:0] w_lo_col;
    logic [COL_W-1:0] w_hi_col;
    logic             w_cfg_ok;
    logic             w_ld_ok;
    logic             w_run;
    logic             w_row_step;
    logic             w_col_step;
    logic             w_row_term;
    logic             w_col_term;
    logic             w_wrap;
    logic [ROW_W-1:0] w_row_val;
    logic [COL_W-1:0] w_col_val;

    axis_mode_e       r_mode;
    logic             r_cout;
    logic             r_done;
    logic             r_cfg_err;

    // Per-field window validation of the incoming load.
    always_comb begin
        w_lo_row = lo_in[ADDR_W-1:COL_W];
        w_hi_row = hi_in[ADDR_W-1:COL_W];
        w_lo_col = lo_in[COL_W-1:0];
        w_hi_col = hi_in[COL_W-1:0];
        w_cfg_ok = (w_lo_row <= w_hi_row) && (w_lo_col <= w_hi_col);
        w_ld_ok  = ld && w_cfg_ok;
    end

    // Step/carry chain: fast axis steps every enabled cycle, slow axis on fast-axis carry.
    always_comb begin
        w_run      = cen && !ld && !r_cfg_err;
        w_col_step = 1'b0;
        w_row_step = 1'b0;
        if (r_mode == COL_FAST) begin
            w_col_step = w_run;
            w_row_step = w_run && w_col_term;
        end else begin
            w_row_step = w_run;
            w_col_step = w_run && w_row_term;
        end
        w_wrap = w_run && w_row_term && w_col_term;
    end

    bist_axis_counter #(.W(ROW_W)) u_row (
        .clk     (clk),
        .reset   (reset),
        .ld      (w_ld_ok),
        .lo      (w_lo_row),
        .hi      (w_hi_row),
        .dir     (dir_e'(dir)),
        .step    (w_row_step),
        .val     (w_row_val),
        .at_term (w_row_term)
    );

    bist_axis_counter #(.W(COL_W)) u_col (
        .clk     (clk),
        .reset   (reset),
        .ld      (w_ld_ok),
        .lo      (w_lo_col),
        .hi      (w_hi_col),
        .dir     (dir_e'(dir)),
        .step    (w_col_step),
        .val     (w_col_val),
        .at_term (w_col_term)
    );

    // Mode latch plus wrap pulse, sticky done and config-error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode    <= COL_FAST;
            r_cout    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (ld) begin
            r_cout <= 1'b0;
            if (w_cfg_ok) begin
                r_mode    <= axis_mode_e'(mode);
                r_done    <= 1'b0;
                r_cfg_err <= 1'b0;
            end else begin
                r_cfg_err <= 1'b1;
            end
        end else begin
            r_cout <= w_wrap;
            if (w_wrap) begin
                r_done <= 1'b1;
            end
        end
    end

    assign q       = {w_row_val, w_col_val};
    assign last    = w_row_term && w_col_term && !r_cfg_err;
    assign cout    = r_cout;
    assign done    = r_done;
    assign cfg_err = r_cfg_err;

endmodule : bist_addr_gen

// File: tb/tb_bist_addr_gen.sv
// Directed self-checking bench for bist_addr_gen (ADDR_W=12, ROW_W=6).
module tb_bist_addr_gen;

    logic        clk;
    logic        reset;
    logic        ld;
    logic        cen;
    logic        dir;
    logic        mode;
    logic [11:0] lo_in;
    logic [11:0] hi_in;
    logic [11:0] q;
    logic        last;
    logic        cout;
    logic        done;
    logic        cfg_err;

    int n_vec;
    int n_err;

    bist_addr_gen #(.ADDR_W(12), .ROW_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .ld      (ld),
        .cen     (cen),
        .dir     (dir),
        .mode    (mode),
        .lo_in   (lo_in),
        .hi_in   (hi_in),
        .q       (q),
        .last    (last),
        .cout    (cout),
        .done    (done),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ld(input logic [11:0] lo, input logic [11:0] hi,
                         input logic d, input logic m, input logic c);
        lo_in = lo;
        hi_in = hi;
        dir   = d;
        mode  = m;
        ld    = 1'b1;
        cen   = c;
        tick();
        ld  = 1'b0;
        cen = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_vec++; if (q !== 12'h000) begin n_err++; $display("FAIL reset_q got %h want 000", q); end
        n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
        n_vec++; if (last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", last); end
    endtask

    task automatic test_full_sweep();
        logic [11:0] exp_q;
        do_ld(12'h000, 12'hFFF, 1'b0, 1'b0, 1'b0);
        exp_q = 12'h000;
        n_vec++; if (q !== exp_q) begin n_err++; $display("FAIL sweep_start got %h want %h", q, exp_q); end
        cen = 1'b1;
        for (int i = 1; i <= 4096; i++) begin
            n_vec++;
            if (last !== (exp_q == 12'hFFF)) begin
                n_err++; $display("FAIL sweep_last step %0d got %b at q=%h", i, last, q);
            end
            tick();
            exp_q = 12'(i);
            n_vec++; if (q !== exp_q) begin n_err++; $display("FAIL sweep_q step %0d got %h want %h", i, q, exp_q); end
            n_vec++;
            if (cout !== (i == 4096)) begin
                n_err++; $display("FAIL sweep_cout step %0d got %b want %b", i, cout, (i == 4096));
            end
            n_vec++;
            if (done !== (i == 4096)) begin
                n_err++; $display("FAIL sweep_done step %0d got %b want %b", i, done, (i == 4096));
            end
        end
        tick();
        cen = 1'b0;
        n_vec++; if (q !== 12'h001) begin n_err++; $display("FAIL sweep_continue got %h want 001", q); end
        n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL sweep_cout_drop got %b want 0", cout); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL sweep_done_sticky got %b want 1", done); end
    endtask

    task automatic test_row_fast_down();
        logic [11:0] seq [4];
        seq[0] = 12'h0C6; seq[1] = 12'h086; seq[2] = 12'h0C5; seq[3] = 12'h085;
        do_ld(12'h085, 12'h0C6, 1'b1, 1'b1, 1'b0);
        n_vec++; if (q !== 12'h0C6) begin n_err++; $display("FAIL rfd_start got %h want 0C6", q); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rfd_done_clear got %b want 0", done); end
        cen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (last !== (i % 4 == 3)) begin
                n_err++; $display("FAIL rfd_last idx %0d got %b want %b", i, last, (i % 4 == 3));
            end
            tick();
            n_vec++;
            if (q !== seq[(i + 1) % 4]) begin
                n_err++; $display("FAIL rfd_q idx %0d got %h want %h", i, q, seq[(i + 1) % 4]);
            end
            n_vec++;
            if (cout !== (i % 4 == 3)) begin
                n_err++; $display("FAIL rfd_cout idx %0d got %b want %b", i, cout, (i % 4 == 3));
            end
        end
        cen = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rfd_done got %b want 1", done); end
    endtask

    task automatic test_single();
        do_ld(12'h123, 12'h123, 1'b0, 1'b0, 1'b0);
        n_vec++; if (q !== 12'h123) begin n_err++; $display("FAIL single_start got %h want 123", q); end
        n_vec++; if (last !== 1'b1) begin n_err++; $display("FAIL single_last0 got %b want 1", last); end
        cen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (q !== 12'h123) begin n_err++; $display("FAIL single_q cyc %0d got %h want 123", i, q); end
            n_vec++; if (last !== 1'b1) begin n_err++; $display("FAIL single_last cyc %0d got %b want 1", i, last); end
            n_vec++; if (cout !== 1'b1) begin n_err++; $display("FAIL single_cout cyc %0d got %b want 1", i, cout); end
        end
        cen = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL single_done got %b want 1", done); end
        tick();
        n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL single_cout_off got %b want 0", cout); end
    endtask

    task automatic test_bad_cfg();
        do_ld(12'h0C0, 12'h085, 1'b0, 1'b0, 1'b0);
        n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL bad_cfg_err got %b want 1", cfg_err); end
        n_vec++; if (q !== 12'h123) begin n_err++; $display("FAIL bad_q_held got %h want 123", q); end
        n_vec++; if (last !== 1'b0) begin n_err++; $display("FAIL bad_last got %b want 0", last); end
        cen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (q !== 12'h123) begin n_err++; $display("FAIL bad_cen_q cyc %0d got %h want 123", i, q); end
            n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL bad_cen_cout cyc %0d got %b want 0", i, cout); end
            n_vec++; if (last !== 1'b0) begin n_err++; $display("FAIL bad_cen_last cyc %0d got %b want 0", i, last); end
        end
        cen = 1'b0;
        do_ld(12'h085, 12'h0C6, 1'b0, 1'b0, 1'b0);
        n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL good_cfg_err got %b want 0", cfg_err); end
        n_vec++; if (q !== 12'h085) begin n_err++; $display("FAIL good_q got %h want 085", q); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL good_done got %b want 0", done); end
    endtask

    task automatic test_priority();
        logic [11:0] seq [4];
        seq[0] = 12'h086; seq[1] = 12'h0C5; seq[2] = 12'h0C6; seq[3] = 12'h085;
        // Window rows 2-3, cols 5-6, up, column-fast, currently at 0x085.
        cen = 1'b1;
        tick();
        tick();
        n_vec++; if (q !== 12'h0C5) begin n_err++; $display("FAIL prio_pre got %h want 0C5", q); end
        do_ld(12'h085, 12'h0C6, 1'b0, 1'b0, 1'b1);
        n_vec++; if (q !== 12'h085) begin n_err++; $display("FAIL prio_ld_cen got %h want 085", q); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (q !== 12'h085) begin n_err++; $display("FAIL prio_hold cyc %0d got %h want 085", i, q); end
        end
        dir  = 1'b1;
        mode = 1'b1;
        cen  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (q !== seq[i]) begin n_err++; $display("FAIL prio_order idx %0d got %h want %h", i, q, seq[i]); end
            n_vec++;
            if (cout !== (i == 3)) begin
                n_err++; $display("FAIL prio_cout idx %0d got %b want %b", i, cout, (i == 3));
            end
        end
        cen  = 1'b0;
        dir  = 1'b0;
        mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_ld(12'h7FF, 12'h7FF, 1'b0, 1'b0, 1'b0);
        cen = 1'b1;
        tick();
        n_vec++; if (q !== 12'h7FF) begin n_err++; $display("FAIL rmid_q got %h want 7FF", q); end
        n_vec++; if (cout !== 1'b1) begin n_err++; $display("FAIL rmid_cout_pre got %b want 1", cout); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (q !== 12'h000) begin n_err++; $display("FAIL rmid_reset_q got %h want 000", q); end
        n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL rmid_reset_cout got %b want 0", cout); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_reset_done got %b want 0", done); end
        n_vec++; if (last !== 1'b0) begin n_err++; $display("FAIL rmid_reset_last got %b want 0", last); end
        tick();
        cen = 1'b0;
        n_vec++; if (q !== 12'h001) begin n_err++; $display("FAIL rmid_full_window got %h want 001", q); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        ld    = 1'b0;
        cen   = 1'b0;
        dir   = 1'b0;
        mode  = 1'b0;
        lo_in = '0;
        hi_in = '0;
        #2;
        test_reset();
        test_full_sweep();
        test_row_fast_down();
        test_single();
        test_bad_cfg();
        test_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bist_addr_gen
